// File: rtl/wb_cellram_ctrl.sv
// Wishbone B3 classic slave for the Micron CellularRAM in asynchronous mode.
// Each 32-bit access becomes two 16-bit RAM accesses, high half first (big-endian).
// Optional one-entry read cache: define CELLRAM_RD_CACHE_EN.
module wb_cellram_ctrl #(
  parameter int unsigned RD_WAIT     = 4,
  parameter int unsigned WR_WAIT     = 4,
  parameter int unsigned INIT_CYCLES = 7500
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [22:0] ram_adr_o,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_ub_n,
  output logic        ram_lb_n,
  output logic        ram_adv_n,
  output logic        ram_clk,
  output logic        ram_cre
);

  // 16 bits covers INIT_CYCLES up to 65536.
  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] InitLoad = CntW'(INIT_CYCLES - 1);
  localparam logic [CntW-1:0] RdLoad   = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] WrLoad   = CntW'(WR_WAIT - 1);

  typedef enum logic [2:0] {StInit, StIdle, StAccHi, StGap1, StAccLo, StGap2, StAck} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [21:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic [15:0]     hi_q, hi_d, lo_q, lo_d;
  logic            ack_d;
  logic [31:0]     dat_o_d;
  logic [22:0]     ram_adr_d;
  logic [15:0]     dq_o_d;
  logic            dq_oe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic            req;
  logic            cache_hit;
  logic [31:0]     cache_dat;
  logic            unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign unused_adr = ^{wb_adr_i[31:24], wb_adr_i[1:0]};
  assign ram_adv_n  = 1'b0;
  assign ram_clk    = 1'b0;
  assign ram_cre    = 1'b0;

`ifdef CELLRAM_RD_CACHE_EN
  logic        cache_vld_q;
  logic [21:0] cache_adr_q;
  logic [31:0] cache_dat_q;

  assign cache_hit = cache_vld_q && !wb_we_i && (cache_adr_q == wb_adr_i[23:2]);
  assign cache_dat = cache_dat_q;

  // Cache entry: invalidated by any write to its word, refilled on read completion.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cache_vld_q <= 1'b0;
      cache_adr_q <= '0;
      cache_dat_q <= '0;
    end else if (state_q == StIdle && req && wb_we_i && cache_adr_q == wb_adr_i[23:2]) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == StGap2 && !we_q) begin
      cache_vld_q <= 1'b1;
      cache_adr_q <= adr_q;
      cache_dat_q <= {hi_q, lo_q};
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_dat = '0;
`endif

  // Next state, request latch, read capture and registered pad values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ack_d     = 1'b0;
    dat_o_d   = wb_dat_o;
    case (state_q)
      StInit: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StIdle: begin
        if (req) begin
          adr_d = wb_adr_i[23:2];
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
          we_d  = wb_we_i;
          if (cache_hit) begin
            state_d = StAck;
            ack_d   = 1'b1;
            dat_o_d = cache_dat;
          end else begin
            state_d = StAccHi;
            cnt_d   = wb_we_i ? WrLoad : RdLoad;
          end
        end
      end
      StAccHi: begin
        if (cnt_q == '0) begin
          if (!we_q) hi_d = ram_dq_i;
          state_d = StGap1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap1: begin
        state_d = StAccLo;
        cnt_d   = we_q ? WrLoad : RdLoad;
      end
      StAccLo: begin
        if (cnt_q == '0) begin
          if (!we_q) lo_d = ram_dq_i;
          state_d = StGap2;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap2: begin
        // An abandoned request finishes on the RAM but is not acknowledged.
        state_d = StAck;
        ack_d   = req;
        if (!we_q) dat_o_d = {hi_q, lo_q};
      end
      StAck:   state_d = StIdle;
      default: state_d = StInit;
    endcase

    // Pad values are derived from the next state so they appear registered.
    ram_adr_d = ram_adr_o;
    dq_o_d    = ram_dq_o;
    dq_oe_d   = 1'b0;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    case (state_d)
      StAccHi, StAccLo: begin
        ce_n_d    = 1'b0;
        ram_adr_d = {adr_d, (state_d == StAccLo)};
        dq_o_d    = (state_d == StAccLo) ? dat_d[15:0] : dat_d[31:16];
        if (we_d) begin
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          ub_n_d  = (state_d == StAccLo) ? !sel_d[1] : !sel_d[3];
          lb_n_d  = (state_d == StAccLo) ? !sel_d[0] : !sel_d[2];
        end else begin
          oe_n_d = 1'b0;
          ub_n_d = 1'b0;
          lb_n_d = 1'b0;
        end
      end
      // Keep driving write data through the gap for data hold time.
      StGap1, StGap2: dq_oe_d = we_d;
      default: ;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= StInit;
      cnt_q     <= InitLoad;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      ram_adr_o <= '0;
      ram_dq_o  <= '0;
      ram_dq_oe <= 1'b0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_ub_n  <= 1'b1;
      ram_lb_n  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wb_ack_o  <= ack_d;
      wb_dat_o  <= dat_o_d;
      ram_adr_o <= ram_adr_d;
      ram_dq_o  <= dq_o_d;
      ram_dq_oe <= dq_oe_d;
      ram_ce_n  <= ce_n_d;
      ram_oe_n  <= oe_n_d;
      ram_we_n  <= we_n_d;
      ram_ub_n  <= ub_n_d;
      ram_lb_n  <= lb_n_d;
    end
  end

endmodule

// File: tb/tb_wb_cellram_ctrl.sv
// Self-checking bench for wb_cellram_ctrl with a behavioural async RAM model.
module tb_wb_cellram_ctrl;

  localparam int unsigned RdW   = 4;
  localparam int unsigned WrW   = 4;
  localparam int unsigned InitN = 50;
  localparam int          LatFull = 2 * RdW + 3;
`ifdef CELLRAM_RD_CACHE_EN
  localparam int          LatHit  = 1;
  localparam int          HitCe   = 0;
`else
  localparam int          LatHit  = LatFull;
  localparam int          HitCe   = 2 * RdW;
`endif

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [22:0] ram_adr_o;
  logic [15:0] ram_dq_i = 16'hDEAD;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n;
  logic        ram_adv_n, ram_clk, ram_cre;

  wb_cellram_ctrl #(
    .RD_WAIT    (RdW),
    .WR_WAIT    (WrW),
    .INIT_CYCLES(InitN)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .ram_adr_o(ram_adr_o),
    .ram_dq_i (ram_dq_i),
    .ram_dq_o (ram_dq_o),
    .ram_dq_oe(ram_dq_oe),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n),
    .ram_ub_n (ram_ub_n),
    .ram_lb_n (ram_lb_n),
    .ram_adv_n(ram_adv_n),
    .ram_clk  (ram_clk),
    .ram_cre  (ram_cre)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc_cnt = 0;
  always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

  // RAM model and pin activity counters, sampled mid-cycle.
  logic [15:0] mem [0:1023] = '{default: 16'h0000};
  int ack_cnt = 0, ce_low_cnt = 0, rd_act_cnt = 0, rd_be_bad = 0;
  int we_low_cnt = 0, we_nobe_cnt = 0, first_ce_cyc = -1;

  always @(negedge wb_clk) begin
    if (wb_ack_o) ack_cnt <= ack_cnt + 1;
    if (!ram_ce_n) begin
      ce_low_cnt <= ce_low_cnt + 1;
      if (first_ce_cyc < 0) first_ce_cyc <= cyc_cnt;
    end
    if (!ram_ce_n && !ram_oe_n) begin
      rd_act_cnt <= rd_act_cnt + 1;
      if (ram_ub_n || ram_lb_n) rd_be_bad <= rd_be_bad + 1;
    end
    if (!ram_ce_n && !ram_we_n) begin
      we_low_cnt <= we_low_cnt + 1;
      if (ram_ub_n && ram_lb_n) we_nobe_cnt <= we_nobe_cnt + 1;
      if (!ram_ub_n) mem[ram_adr_o[9:0]][15:8] <= ram_dq_o[15:8];
      if (!ram_lb_n) mem[ram_adr_o[9:0]][7:0]  <= ram_dq_o[7:0];
    end
    ram_dq_i <= (!ram_ce_n && !ram_oe_n) ? mem[ram_adr_o[9:0]] : 16'hDEAD;
  end

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] dat;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One WB transfer starting at posedge+1; expectation goes through the scoreboard.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int lat, input logic [31:0] rdat,
                         input string tag);
    exp_t e;
    int   n;
    bit   seen;
    e.tag = tag; e.we = we; e.dat = rdat; e.lat = lat;
    exp_q.push_back(e);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < int'(InitN) + 100) begin
      @(negedge wb_clk);
      if (wb_ack_o) seen = 1'b1;
      else begin
        @(posedge wb_clk); #1;
        n++;
      end
    end
    e = exp_q.pop_front();
    check_eq({e.tag, "_ack"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({e.tag, "_lat"}, 32'(n), 32'(e.lat));
      if (!e.we) check_eq({e.tag, "_dat"}, wb_dat_o, e.dat);
    end
    @(posedge wb_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, b0, b1;
    wb_rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    check_eq("rst_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n}), 32'h1F);
    check_eq("rst_dq_oe", 32'(ram_dq_oe), 32'd0);
    check_eq("rst_adr", 32'(ram_adr_o), 32'd0);
    check_eq("rst_dq_o", 32'(ram_dq_o), 32'd0);
    check_eq("tied_pins", 32'({ram_adv_n, ram_clk, ram_cre}), 32'd0);

    // Request raised two cycles after reset release waits out the init period.
    wb_rst = 1'b0;
    rel = cyc_cnt;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_xfer(1'b1, 32'h0000_0300, 32'h5A5A_0F0F, 4'hF, int'(InitN) + 9, 32'h0, "init_wr");
    check_eq("init_first_ce", 32'(first_ce_cyc - rel), 32'(InitN + 1));
    check_eq("init_mem_hi", 32'(mem[10'h180]), 32'h5A5A);
    check_eq("init_mem_lo", 32'(mem[10'h181]), 32'h0F0F);

    wb_xfer(1'b1, 32'h0000_0100, 32'hA1B2_C3D4, 4'hF, LatFull, 32'h0, "wr_full");
    check_eq("wr_mem_hi", 32'(mem[10'h080]), 32'hA1B2);
    check_eq("wr_mem_lo", 32'(mem[10'h081]), 32'hC3D4);

    // Read with sel=0 still enables both bytes.
    b0 = rd_be_bad; b1 = rd_act_cnt;
    wb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, LatFull, 32'hA1B2_C3D4, "rd_full");
    check_eq("rd_be_bad", 32'(rd_be_bad - b0), 32'd0);
    check_eq("rd_act_cycles", 32'(rd_act_cnt - b1), 32'(2 * RdW));

    // Single-byte write; the low half still pulses we_n with no byte enabled.
    b0 = we_low_cnt; b1 = we_nobe_cnt;
    wb_xfer(1'b1, 32'h0000_0100, 32'h00EE_0000, 4'b0100, LatFull, 32'h0, "wr_byte");
    check_eq("wr_byte_we_cycles", 32'(we_low_cnt - b0), 32'(2 * WrW));
    check_eq("wr_byte_nobe_cycles", 32'(we_nobe_cnt - b1), 32'(WrW));
    wb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, LatFull, 32'hA1EE_C3D4, "rd_after_byte");

    // Abandoned write: RAM still written, no acknowledge.
    b0 = ack_cnt;
    wb_adr_i = 32'h0000_0200; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (5) @(posedge wb_clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (15) @(posedge wb_clk);
    #1;
    check_eq("abort_no_ack", 32'(ack_cnt - b0), 32'd0);
    check_eq("abort_mem_hi", 32'(mem[10'h100]), 32'h1234);
    check_eq("abort_mem_lo", 32'(mem[10'h101]), 32'h5678);

    // Asynchronous reset in the middle of a read.
    wb_adr_i = 32'h0000_0100; wb_sel_i = 4'hF; wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    check_eq("midrd_ce_active", 32'(ram_ce_n), 32'd0);
    #2 wb_rst = 1'b1;
    #1;
    check_eq("midrd_rst_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
    check_eq("midrd_rst_dq_oe", 32'(ram_dq_oe), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    repeat (InitN + 2) @(posedge wb_clk);
    #1;

    // Repeat reads; with the cache the second one hits without touching the RAM.
    wb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, LatFull, 32'hA1EE_C3D4, "rd_post_rst");
    b0 = ce_low_cnt;
    wb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, LatHit, 32'hA1EE_C3D4, "rd_repeat");
    check_eq("rd_repeat_ce_cycles", 32'(ce_low_cnt - b0), 32'(HitCe));
    wb_xfer(1'b1, 32'h0000_0100, 32'hA1B2_C3D4, 4'hF, LatFull, 32'h0, "wr_inval");
    wb_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, LatFull, 32'hA1B2_C3D4, "rd_after_inval");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
